// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/response bundle between EX stage and the iterative multiply/divide unit
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic                   Flush;
    logic                   MDUStart;
    logic [1:0]             MDUOp;
    logic [WIDTH-1:0]       SrcA;
    logic [WIDTH-1:0]       SrcB;
    logic                   MDUBusy;
    logic                   MDUDone;
    logic [2*WIDTH-1:0]     MDUResult;

    modport master (
        output Flush, MDUStart, MDUOp, SrcA, SrcB,
        input  MDUBusy, MDUDone, MDUResult
    );

    modport slave (
        input  Flush, MDUStart, MDUOp, SrcA, SrcB,
        output MDUBusy, MDUDone, MDUResult
    );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit producing {Hi,Lo}
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    mdu_iter_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dz_q, dz_d;
    logic [2*WIDTH-1:0]   res_q, res_d;

    logic                 busy, done;
    logic                 start_ok;
    logic                 is_signed;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum, partial, trial;
    logic                 fits;
    logic [2*WIDTH-1:0]   prod;

    // Operand conditioning: signed ops work on magnitudes, signs are fixed up in FIX
    assign start_ok  = bus.MDUStart & ~bus.Flush;
    assign is_signed = ~bus.MDUOp[0];
    assign a_mag     = (is_signed & bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
    assign b_mag     = (is_signed & bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;

    // Shift-add step: add multiplicand into the high half when the multiplier LSB is set
    assign sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // Restoring divide step: shift the next dividend bit into the partial remainder
    assign partial = {hi_q, lo_q[WIDTH-1]};
    assign trial   = partial - {1'b0, b_q};
    assign fits    = (partial >= {1'b0, b_q});
    assign prod    = {hi_q, lo_q};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Flush returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.Flush) state_d = S_IDLE;
    end

    // Status outputs; a Flush in the DONE cycle swallows the pulse
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE) & ~bus.Flush;
    end

    assign bus.MDUBusy   = busy;
    assign bus.MDUDone   = done;
    assign bus.MDUResult = res_q;

    // Datapath next-value logic: latch on start, iterate in RUN, sign-correct in FIX
    always_comb begin
        op_d      = op_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        a_raw_d   = a_raw_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        res_d     = res_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    op_d      = bus.MDUOp;
                    cnt_d     = '0;
                    hi_d      = '0;
                    lo_d      = bus.MDUOp[1] ? a_mag : b_mag;
                    b_d       = bus.MDUOp[1] ? b_mag : a_mag;
                    a_raw_d   = bus.SrcA;
                    neg_d     = is_signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
                    neg_rem_d = is_signed & bus.SrcA[WIDTH-1];
                    dz_d      = bus.MDUOp[1] & (bus.SrcB == '0);
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (!op_q[1]) begin
                    hi_d = sum[WIDTH:1];
                    lo_d = {sum[0], lo_q[WIDTH-1:1]};
                end else if (fits) begin
                    hi_d = trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = partial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end
            S_FIX: begin
                if (!bus.Flush) begin
                    if (!op_q[1]) begin
                        res_d = neg_q ? -prod : prod;
                    end else if (dz_q) begin
                        res_d = {a_raw_q, {WIDTH{1'b1}}};
                    end else begin
                        res_d = {(neg_rem_q ? -hi_q : hi_q), (neg_q ? -lo_q : lo_q)};
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            a_raw_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            res_q     <= '0;
        end else begin
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            a_raw_q   <= a_raw_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            res_q     <= res_d;
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard bench for mdu_iter with a reference arithmetic model
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_last = '0;

    mdu_iter_if #(.WIDTH(32)) bus ();
    mdu_iter #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'd0: return 64'(sa * sb);
            2'd1: return ua * ub;
            2'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {(ua % ub) << 32} | (ua / ub);
            end
        endcase
    endfunction

    // Monitor: every MDUDone must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.MDUDone === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", bus.MDUResult, e.res);
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    exp_last = e.res;
                end
            end
        end
    end

    // Issue one op at this negedge, then sit out its full latency checking MDUBusy
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int ts, nbusy;
        exp_t e;
        ts = cyc;
        bus.MDUStart = 1'b1;
        bus.MDUOp    = op;
        bus.SrcA     = a;
        bus.SrcB     = b;
        e.res = exp;
        e.cyc = ts + 34;
        exp_q.push_back(e);
        @(negedge clk);
        bus.MDUStart = 1'b0;
        bus.SrcA     = $urandom;
        bus.SrcB     = $urandom;
        nbusy = 0;
        for (int k = 1; k <= 35; k++) begin
            if (bus.MDUBusy === 1'b1) nbusy++;
            if (k < 35) @(negedge clk);
        end
        check("busy_cycles", 64'(nbusy), 64'd34);
        check("idle_after_done", 64'(bus.MDUBusy), 64'd0);
    endtask

    task automatic start_only(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.MDUStart = 1'b1;
        bus.MDUOp    = op;
        bus.SrcA     = a;
        bus.SrcB     = b;
        @(negedge clk);
        bus.MDUStart = 1'b0;
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        int          ts, sel;
        exp_t        e;

        bus.Flush    = 1'b0;
        bus.MDUStart = 1'b0;
        bus.MDUOp    = 2'd0;
        bus.SrcA     = '0;
        bus.SrcB     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 64'(bus.MDUBusy), 64'd0);
        check("reset_done", 64'(bus.MDUDone), 64'd0);
        check("reset_result", bus.MDUResult, 64'd0);

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7,          64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2,          64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  64'h0000_0000_8000_0000);
        run_op(2'd3, 32'd100,       32'd0,          64'h0000_0064_FFFF_FFFF);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd0,          64'hFFFF_FFF9_FFFF_FFFF);

        // Flush mid-run, then restart two cycles later
        ts = cyc;
        start_only(2'd1, 32'd5, 32'd6);
        while (cyc < ts + 10) @(negedge clk);
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        check("flush_busy", 64'(bus.MDUBusy), 64'd0);
        check("flush_result_hold", bus.MDUResult, exp_last);
        @(negedge clk);
        run_op(2'd3, 32'd9, 32'd4, 64'h0000_0001_0000_0002);

        // Flush together with start in IDLE: nothing starts
        bus.Flush = 1'b1;
        start_only(2'd0, 32'd3, 32'd3);
        bus.Flush = 1'b0;
        check("flush_start_busy", 64'(bus.MDUBusy), 64'd0);
        @(negedge clk);

        // Start while busy is ignored; only the first op completes
        ts = cyc;
        e.res = ref_mdu(2'd1, 32'd1234, 32'd5678);
        e.cyc = ts + 34;
        exp_q.push_back(e);
        start_only(2'd1, 32'd1234, 32'd5678);
        while (cyc < ts + 5) @(negedge clk);
        start_only(2'd0, 32'hFFFF_FFFF, 32'd77);
        while (cyc < ts + 36) @(negedge clk);
        check("busy_start_ignored", 64'(bus.MDUBusy), 64'd0);

        // Flush in the DONE cycle: no pulse, but the result is already registered
        ts = cyc;
        start_only(2'd1, 32'd300, 32'd7);
        while (cyc < ts + 33) @(negedge clk);
        @(posedge clk);
        #1 bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        @(negedge clk);
        check("flush_done_busy", 64'(bus.MDUBusy), 64'd0);
        check("flush_done_result", bus.MDUResult, 64'd2100);
        exp_last = 64'd2100;

        // Reset mid-operation
        ts = cyc;
        start_only(2'd2, 32'hFFFF_FF00, 32'd3);
        while (cyc < ts + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(bus.MDUBusy), 64'd0);
        check("rst_done", 64'(bus.MDUDone), 64'd0);
        check("rst_result", bus.MDUResult, 64'd0);
        @(negedge clk);

        // Randomised back-to-back ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) b = 32'($urandom_range(1, 15));
            else if (sel == 2) a = 32'h8000_0000;
            else if (sel == 3) b = 32'hFFFF_FFFF;
            run_op(op, a, b, ref_mdu(op, a, b));
        end

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
